ad7686_reader: RTL and testbench

- SPI reader for a 16-bit SAR ADC (AD7686-class, 3-wire CS mode, no busy indicator).
- Paces conversions at a fixed sample period and drives CNV and SCLK.
- Shifts in the result MSB-first and presents each word on an AXI4-Stream master port.
- Acquisition-side counterpart to the team's AD5543 DAC writer; sits in the DNCCTP subsystem.

---
 rtl/ad7686_reader.sv | 151 +++++++++++++++
 tb/tb_ad7686_reader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ad7686_reader.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | ad7686_reader                                                            |
// | Paced CNV/SCLK reader for a 16-bit SAR ADC, results on an AXIS master.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ad7686_reader #(
  parameter int DW          = 16,
  parameter int IFREQ       = 96,
  parameter int PERIOD      = 192,
  parameter int CONV_CYCLES = 70,
  parameter int GAP_CYCLES  = 2,
  parameter int SCLK_HALF   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic          cnv,
  output logic          sclk,
  input  logic          sdo,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic [DW-1:0] m_axis_tdata,
  output logic          busy,
  output logic          ovr
);

  localparam int c_PW  = $clog2(PERIOD);
  localparam int c_CW  = $clog2((CONV_CYCLES > GAP_CYCLES ? CONV_CYCLES : GAP_CYCLES) + 1);
  localparam int c_HW  = $clog2(2 * SCLK_HALF);
  localparam int c_BW  = $clog2(DW);
  localparam int c_LAT = 1 + CONV_CYCLES + GAP_CYCLES + 2 * SCLK_HALF * DW;

  localparam logic [c_PW-1:0] c_PCNT_LAST = c_PW'(PERIOD - 1);
  localparam logic [c_CW-1:0] c_CONV_LAST = c_CW'(CONV_CYCLES - 1);
  localparam logic [c_CW-1:0] c_GAP_LAST  = c_CW'(GAP_CYCLES - 1);
  localparam logic [c_HW-1:0] c_PH_LAST   = c_HW'(2 * SCLK_HALF - 1);
  localparam logic [c_HW-1:0] c_PH_HIGH   = c_HW'(SCLK_HALF);
  localparam logic [c_BW-1:0] c_BIT_LAST  = c_BW'(DW - 1);

  localparam logic [2:0] c_S_IDLE  = 3'd0;
  localparam logic [2:0] c_S_CONV  = 3'd1;
  localparam logic [2:0] c_S_GAP   = 3'd2;
  localparam logic [2:0] c_S_SHIFT = 3'd3;
  localparam logic [2:0] c_S_DONE  = 3'd4;

  // A tick must always find the FSM idle, otherwise samples would be silently lost.
  if (c_LAT + 1 > PERIOD || GAP_CYCLES < 1 || IFREQ < 1) begin : g_timing_check
    $error("ad7686_reader: latency %0d does not fit sample period %0d", c_LAT, PERIOD);
  end

  logic [2:0]      r_state;
  logic [c_PW-1:0] r_pcnt;
  logic [c_CW-1:0] r_cnt;
  logic [c_HW-1:0] r_ph;
  logic [c_BW-1:0] r_bit;
  logic [DW-1:0]   r_shift;
  logic [DW-1:0]   r_tdata;
  logic            r_cnv, r_sclk, r_tvalid, r_busy, r_ovr;

  logic [2:0]      w_state_nxt;
  logic [c_CW-1:0] w_cnt_nxt;
  logic [c_HW-1:0] w_ph_nxt;
  logic [c_BW-1:0] w_bit_nxt;
  logic            w_cnv_nxt, w_sclk_nxt, w_busy_nxt, w_ovr_nxt, w_sample, w_load;

  wire w_tick    = en && (r_pcnt == '0);
  wire w_blocked = r_tvalid && !m_axis_tready;
  wire w_ph_end  = (r_ph == c_PH_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_IDLE:  if (w_tick && !w_blocked)               w_state_nxt = c_S_CONV;
      c_S_CONV:  if (r_cnt == c_CONV_LAST)                w_state_nxt = c_S_GAP;
      c_S_GAP:   if (r_cnt == c_GAP_LAST)                 w_state_nxt = c_S_SHIFT;
      c_S_SHIFT: if (w_ph_end && (r_bit == c_BIT_LAST))  w_state_nxt = c_S_DONE;
      c_S_DONE:                                           w_state_nxt = c_S_IDLE;
      default:                                            w_state_nxt = c_S_IDLE;
    endcase
  end

  // Outputs are computed from the next state so they register in step with it.
  always_comb begin
    w_cnt_nxt = '0;
    if ((w_state_nxt == r_state) && ((r_state == c_S_CONV) || (r_state == c_S_GAP)))
      w_cnt_nxt = r_cnt + 1'b1;
    w_ph_nxt   = '0;
    w_bit_nxt  = '0;
    if (r_state == c_S_SHIFT) begin
      w_ph_nxt  = w_ph_end ? '0 : r_ph + 1'b1;
      w_bit_nxt = w_ph_end ? r_bit + 1'b1 : r_bit;
    end
    w_cnv_nxt  = (w_state_nxt == c_S_CONV);
    w_sclk_nxt = (w_state_nxt == c_S_SHIFT) && (w_ph_nxt >= c_PH_HIGH);
    w_busy_nxt = (w_state_nxt != c_S_IDLE);
    w_ovr_nxt  = (r_state == c_S_IDLE) && w_tick && w_blocked;
    w_sample   = (r_state == c_S_SHIFT) && w_ph_end;
    w_load     = (r_state == c_S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt   <= '0;
      r_cnt    <= '0;
      r_ph     <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_tdata  <= '0;
      r_cnv    <= 1'b0;
      r_sclk   <= 1'b0;
      r_tvalid <= 1'b0;
      r_busy   <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      if (!en)                        r_pcnt <= '0;
      else if (r_pcnt == c_PCNT_LAST) r_pcnt <= '0;
      else                            r_pcnt <= r_pcnt + 1'b1;
      r_cnt  <= w_cnt_nxt;
      r_ph   <= w_ph_nxt;
      r_bit  <= w_bit_nxt;
      r_cnv  <= w_cnv_nxt;
      r_sclk <= w_sclk_nxt;
      r_busy <= w_busy_nxt;
      r_ovr  <= w_ovr_nxt;
      // Sampled on the edge that drops SCLK, before the ADC moves to the next bit.
      if (w_sample) r_shift <= {r_shift[DW-2:0], sdo};
      if (w_load) begin
        r_tvalid <= 1'b1;
        r_tdata  <= r_shift;
      end else if (r_tvalid && m_axis_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign cnv           = r_cnv;
  assign sclk          = r_sclk;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tdata  = r_tdata;
  assign busy          = r_busy;
  assign ovr           = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_ad7686_reader.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ad7686_reader                                                         |
// | Scoreboard bench for ad7686_reader with a behavioural ADC model.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ad7686_reader;
  localparam int DW          = 16;
  localparam int PERIOD      = 100;
  localparam int CONV_CYCLES = 20;
  localparam int GAP_CYCLES  = 2;
  localparam int SCLK_HALF   = 2;
  localparam int L           = 1 + CONV_CYCLES + GAP_CYCLES + 2 * SCLK_HALF * DW;

  if (L + 1 > PERIOD) begin : g_timing_check
    $error("latency %0d does not fit period %0d", L, PERIOD);
  end

  logic          clk = 1'b0, rst_n = 1'b0, en = 1'b0, sdo = 1'b0, tready = 1'b1;
  logic          cnv, sclk, tvalid, busy, ovr;
  logic [DW-1:0] tdata;

  ad7686_reader #(
    .DW(DW), .IFREQ(96), .PERIOD(PERIOD), .CONV_CYCLES(CONV_CYCLES),
    .GAP_CYCLES(GAP_CYCLES), .SCLK_HALF(SCLK_HALF)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cnv(cnv), .sclk(sclk), .sdo(sdo),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tdata(tdata),
    .busy(busy), .ovr(ovr)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever @(posedge clk) cyc++;

  int n_total = 0, n_bad = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [DW-1:0] word;
    int            due;
  } exp_t;
  exp_t exp_q[$];

  logic [DW-1:0] words [8] = '{16'hA5C3, 16'h0000, 16'hFFFF, 16'h8001,
                               16'h7FFE, 16'h1234, 16'h5A3C, 16'hC0DE};
  int widx = 0;

  // ADC: MSB valid from CNV falling, next bit after each SCLK falling edge.
  logic [DW-1:0] adc_word = '0;
  int            adc_bit  = 0;
  initial forever begin
    @(negedge cnv);
    adc_bit = DW - 1;
    sdo     = adc_word[adc_bit];
  end
  initial forever begin
    @(negedge sclk);
    if (adc_bit > 0) begin
      adc_bit = adc_bit - 1;
      sdo     = adc_word[adc_bit];
    end
  end

  logic p_cnv = 0, p_tv = 0, p_tr = 0, p_sclk = 0, p_tick = 0, p_blk = 0, p_en = 0;
  int   m_pcnt = 0, cnv_hi = 0, sclk_n = 0, last_sclk = 0, last_tv = 0;
  int   n_cnv = 0, n_ovr = 0, n_tv = 0;
  bit   spacing_on = 0;
  logic [DW-1:0] cur_word = '0;

  // Monitor: reference period counter plus scoreboard pop on every new word.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      m_pcnt = 0;
      p_tick = 0;
      p_blk  = 0;
      p_en   = 0;
    end else begin
      check("cnv_rise_at_tick", 32'(cnv && !p_cnv), 32'(p_tick && !p_blk));
      check("ovr_at_blocked_tick", 32'(ovr), 32'(p_tick && p_blk));
      if (cnv && !p_cnv) begin
        n_cnv++;
        adc_word = words[widx % 8];
        e.word   = words[widx % 8];
        e.due    = cyc + L;
        exp_q.push_back(e);
        widx++;
        cnv_hi = 0;
        sclk_n = 0;
        check("busy_on_start", 32'(busy), 1);
      end
      if (cnv) cnv_hi++;
      if (!cnv && p_cnv) check("cnv_width", cnv_hi, CONV_CYCLES);
      if (sclk && !p_sclk) begin
        if (sclk_n > 0) check("sclk_period", cyc - last_sclk, 2 * SCLK_HALF);
        sclk_n++;
        last_sclk = cyc;
      end
      if (ovr) n_ovr++;
      if (tvalid && !p_tv) begin
        n_tv++;
        check("tvalid_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("latency", cyc, e.due);
          check("tdata", 32'(tdata), 32'(e.word));
          check("sclk_count", sclk_n, DW);
          check("busy_done", 32'(busy), 0);
          cur_word = e.word;
          if (spacing_on && last_tv > 0) check("spacing", cyc - last_tv, PERIOD);
          last_tv = cyc;
        end
      end else if (tvalid) begin
        check("tdata_hold", 32'(tdata), 32'(cur_word));
      end
      if (p_tv && p_tr) check("tvalid_drop", 32'(tvalid), 0);
      m_pcnt = p_en ? ((m_pcnt == PERIOD - 1) ? 0 : m_pcnt + 1) : 0;
      p_tick = en && (m_pcnt == 0);
      p_blk  = tvalid && !tready;
      p_en   = en;
    end
    p_cnv  = cnv;
    p_tv   = tvalid;
    p_tr   = tready;
    p_sclk = sclk;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_tv(input int target, input int budget);
    int k = 0;
    while (n_tv < target && k < budget) begin
      step(1);
      k++;
    end
    check("tvalid_wait", 32'(n_tv >= target), 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int ovr0, cnv0, tv0;
    step(3);
    check("rst_cnv", 32'(cnv), 0);
    check("rst_sclk", 32'(sclk), 0);
    check("rst_tvalid", 32'(tvalid), 0);
    check("rst_tdata", 32'(tdata), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ovr", 32'(ovr), 0);
    rst_n = 1;
    step(5);

    // single sample followed by continuous sampling, no backpressure
    spacing_on = 1;
    en = 1;
    wait_tv(6, 800);
    check("ovr_continuous", n_ovr, 0);
    spacing_on = 0;

    // backpressure: word 7 held, next tick skipped, resumes at the following tick
    tready = 0;
    wait_tv(7, 300);
    ovr0 = n_ovr;
    cnv0 = n_cnv;
    step(60);
    check("ovr_backpressure", n_ovr - ovr0, 1);
    check("cnv_skipped", n_cnv - cnv0, 0);
    tready = 1;
    step(2);

    // accept exactly on the tick cycle frees the register for a new conversion
    tready = 0;
    wait_tv(8, 300);
    step(11);
    tready = 1;
    ovr0 = n_ovr;
    cnv0 = n_cnv;
    step(2);
    check("ovr_tick_handshake", n_ovr - ovr0, 0);
    check("cnv_tick_handshake", n_cnv - cnv0, 1);

    // en dropped mid-conversion: current word still delivered, nothing after
    step(9);
    en = 0;
    cnv0 = n_cnv;
    tv0  = n_tv;
    wait_tv(tv0 + 1, 200);
    step(150);
    check("cnv_after_en_drop", n_cnv - cnv0, 0);
    en = 1;
    step(1);
    check("cnv_reassert", 32'(cnv), 1);

    // asynchronous reset during bit 8 of the shift
    step(54);
    check("busy_pre_reset", 32'(busy), 1);
    tv0 = n_tv;
    #2;
    rst_n = 0;
    #1;
    check("arst_cnv", 32'(cnv), 0);
    check("arst_sclk", 32'(sclk), 0);
    check("arst_tvalid", 32'(tvalid), 0);
    check("arst_busy", 32'(busy), 0);
    check("pending_word", exp_q.size(), 1);
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    step(2);
    rst_n = 1;
    wait_tv(tv0 + 1, 200);
    check("one_word_after_reset", n_tv - tv0, 1);

    step(5);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
